rx_uart_128: RTL and testbench
==============================

Name: rx_uart_128

Overview:
- Receive side of the 128-bit UART link.
- Deserialises 8N1 frames from the serial line, LSB first per byte, and assembles 16 consecutive bytes into one 128-bit word.
- Byte order is MSB-first at word level: the first received byte lands in data_out[127:120], matching the 128-bit transmitter's byte order.
- Contains its own oversampling bit receiver; no external byte-level module is required.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit period; must be ≥ 4.
- WORD_BYTES, 16, bytes per assembled word; data_out width = 8*WORD_BYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en_rx  input  1  receive enable; low forces IDLE and discards any partial word.
- u_rx  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  128  last complete word; holds until the next word completes.
- u_rx_done  output  1  one-cycle pulse when data_out is updated.
- u_rx_busy  output  1  high while a frame is in progress or a partial word is held (byte count ≠ 0).
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- rx_timeout  output  1  one-cycle pulse on inter-byte timeout; constant 0 unless RX_TIMEOUT_EN is defined.

Behaviour:
- Reset, asynchronous: FSM=IDLE, bit counter=0, byte count=0, assembly register=0, data_out=0, all pulse outputs=0, synchroniser flops=1.
- Input conditioning: u_rx passes through a 2-flop synchroniser. All sampling uses the synchronised value; this adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: with en_rx=1, a synchronised low moves the FSM to START and clears the baud counter.
- START: at baud count CLKS_PER_BIT/2-1 (mid start bit), re-sample the line.
  - Still low: go to DATA with bit index 0 and baud counter cleared.
  - High: treat as a glitch and return to IDLE. No error is flagged.
- DATA: sample every CLKS_PER_BIT cycles; bit i goes to byte[i]. After bit 7, go to STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample = 1: the byte is valid. Shift it in: asm <= {asm[119:0], byte}; byte count increments.
  - Sample = 0: pulse frame_err, discard the byte, clear the byte count (the partial word is dropped).
  - Either case: return to IDLE immediately, so back-to-back frames with a single stop bit are accepted.
- Word completion: when the 16th valid byte is accepted, the next cycle applies data_out <= assembled word, u_rx_done=1 for exactly one cycle, and byte count=0. The assembly register is not cleared.
- en_rx deasserted in any state: on the next clk the FSM goes to IDLE, byte count=0, and no pulses are generated. data_out keeps its last value.
- Re-asserting en_rx while the line is low: no start is detected until the line has been seen high at least once. This prevents mid-frame lock-on.
- Counters:
  - Baud counter width is clog2(CLKS_PER_BIT).
  - Byte count is 4 bits and wraps 15→0 only on word completion.
- Simultaneous events: a frame error on byte 16 produces frame_err only; there is no u_rx_done.
- Busy: u_rx_busy = (state≠IDLE) || (byte count≠0).

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while state=IDLE and byte count≠0. It resets on each start detection.
  - When it reaches 20*CLKS_PER_BIT (two character times), the partial word is dropped, byte count=0, and rx_timeout pulses for one cycle.
  - data_out is untouched.
- Undefined: no idle counter. Partial words wait indefinitely. rx_timeout is tied to 0.

Test Plan:
- CLKS_PER_BIT=16: send bytes 0x00,0x11,…,0xFF back-to-back → one u_rx_done pulse; data_out=128'h00112233445566778899AABBCCDDEEFF; busy low afterwards.
- Send 16 bytes where byte 5 has stop bit=0 → frame_err pulse at that byte's stop sample; byte count=0. A following clean 16 bytes of 0xA5 → data_out=all 0xA5, exactly one u_rx_done.
- Low glitch of 4 cycles on an idle line → FSM returns to IDLE; no pulses; busy low after the glitch.
- Assert rst_n=0 after 7 bytes, then release and send 16 bytes 0x5A → data_out=16×0x5A, single done pulse, no leftover bytes from before reset.
- Drop en_rx for 1 cycle mid-byte 9, then send 16 bytes of 0x3C → only the last 16 bytes form the word; data_out=16×0x3C.
- RX_TIMEOUT_EN defined: send 3 bytes, then idle for 20*16 cycles → rx_timeout pulses once, busy goes low, data_out unchanged. Without the macro, rx_timeout stays 0 and busy stays high.

Source files
------------

// File: rtl/rx_uart_128.sv
// ============================================================================
// Module   : rx_uart_128
// Purpose  : 8N1 UART receiver assembling WORD_BYTES bytes (MSB-first) per word.
//            Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_uart_128 #(
  parameter int CLKS_PER_BIT = 87,
  parameter int WORD_BYTES   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_rx,
  input  logic                      u_rx,
  output logic [8*WORD_BYTES-1:0]   data_out,
  output logic                      u_rx_done,
  output logic                      u_rx_busy,
  output logic                      frame_err,
  output logic                      rx_timeout
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(WORD_BYTES);
  localparam int                WORD_W    = 8 * WORD_BYTES;
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic              rx_s1_q, rx_s2_q;
  logic              armed_q;
  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        byte_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] data_q;
  logic              pend_q;
  logic              done_q;
  logic              ferr_q;
  logic              start_w;

  // Start only after the line has been seen high while enabled, so a
  // re-enable in the middle of a frame cannot lock onto a data bit.
  assign start_w = en_rx && armed_q && !rx_s2_q && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= u_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(20 * CLKS_PER_BIT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(20 * CLKS_PER_BIT - 1);
  logic [TO_W-1:0] idle_q;
  logic            to_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef RX_TIMEOUT_EN
      idle_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= en_rx && (armed_q || rx_s2_q);
`ifdef RX_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
      if (!en_rx) begin
        state_q <= IDLE;
        baud_q  <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
`ifdef RX_TIMEOUT_EN
        idle_q  <= '0;
`endif
      end else begin
        // Word publish lags the 16th stop sample by one cycle.
        if (pend_q) begin
          data_q <= asm_q;
          done_q <= 1'b1;
          cnt_q  <= '0;
          pend_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (start_w) begin
              state_q <= START;
              baud_q  <= '0;
            end
          end
          START: begin
            if (baud_q == HALF_LAST) begin
              baud_q  <= '0;
              bit_q   <= '0;
              state_q <= rx_s2_q ? IDLE : DATA;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          DATA: begin
            if (baud_q == FULL_LAST) begin
              baud_q <= '0;
              byte_q <= {rx_s2_q, byte_q[7:1]};
              if (bit_q == 3'd7) state_q <= STOP;
              else               bit_q   <= bit_q + 1'b1;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          STOP: begin
            if (baud_q == FULL_LAST) begin
              baud_q  <= '0;
              state_q <= IDLE;
              if (rx_s2_q) begin
                asm_q <= {asm_q[WORD_W-9:0], byte_q};
                if (cnt_q == LAST_BYTE) pend_q <= 1'b1;
                else                    cnt_q  <= cnt_q + 1'b1;
              end else begin
                ferr_q <= 1'b1;
                cnt_q  <= '0;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
`ifdef RX_TIMEOUT_EN
        if ((state_q == IDLE) && (cnt_q != '0) && !start_w && !pend_q) begin
          if (idle_q == TO_LAST) begin
            idle_q <= '0;
            cnt_q  <= '0;
            to_q   <= 1'b1;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end else begin
          idle_q <= '0;
        end
`endif
      end
    end
  end

  assign data_out  = data_q;
  assign u_rx_done = done_q;
  assign frame_err = ferr_q;
  assign u_rx_busy = (state_q != IDLE) || (cnt_q != '0);
`ifdef RX_TIMEOUT_EN
  assign rx_timeout = to_q;
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_uart_128.sv
// ============================================================================
// Module   : tb_rx_uart_128
// Purpose  : Directed self-checking bench for rx_uart_128 at 16 clocks/bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_uart_128;

  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_rx;
  logic         u_rx;
  logic [127:0] data_out;
  logic         u_rx_done;
  logic         u_rx_busy;
  logic         frame_err;
  logic         rx_timeout;

  int tests  = 0;
  int failed = 0;
  int done_cnt = 0, ferr_cnt = 0, to_cnt = 0;
  int done0, ferr0, to0;
  logic [127:0] word_snap;

  rx_uart_128 #(.CLKS_PER_BIT(CPB), .WORD_BYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_rx     (en_rx),
    .u_rx      (u_rx),
    .data_out  (data_out),
    .u_rx_done (u_rx_done),
    .u_rx_busy (u_rx_busy),
    .frame_err (frame_err),
    .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  // Pulse widths are measured by counting high cycles mid-period.
  always @(negedge clk) begin
    if (u_rx_done)  done_cnt++;
    if (frame_err)  ferr_cnt++;
    if (rx_timeout) to_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int drop_bit);
    u_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      u_rx = b[i];
      if (i == drop_bit) begin
        tick(CPB / 2);
        en_rx = 1'b0;
        tick(1);
        en_rx = 1'b1;
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB);
      end
    end
    u_rx = !bad_stop;
    tick(CPB);
    u_rx = 1'b1;
  endtask

  task automatic snap();
    done0 = done_cnt;
    ferr0 = ferr_cnt;
    to0   = to_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    en_rx = 1'b1;
    u_rx  = 1'b1;
    tick(3);
    check("rst_data",    data_out,   128'h0);
    check("rst_done",    u_rx_done,  128'h0);
    check("rst_busy",    u_rx_busy,  128'h0);
    check("rst_ferr",    frame_err,  128'h0);
    check("rst_timeout", rx_timeout, 128'h0);
    rst_n = 1'b1;
    tick(5);

    // Short low glitch on idle line
    snap();
    u_rx = 1'b0;
    tick(4);
    check("glitch_busy_mid", u_rx_busy, 128'h1);
    u_rx = 1'b1;
    tick(30);
    check("glitch_busy_after", u_rx_busy, 128'h0);
    check("glitch_done", 128'(done_cnt - done0), 128'h0);
    check("glitch_ferr", 128'(ferr_cnt - ferr0), 128'h0);

    // 0x00,0x11..0xFF back-to-back
    snap();
    for (int i = 0; i < 16; i++) send_byte(8'(i * 8'h11), 1'b0, -1);
    tick(4);
    check("seq_done", 128'(done_cnt - done0), 128'h1);
    check("seq_ferr", 128'(ferr_cnt - ferr0), 128'h0);
    check("seq_data", data_out, 128'h00112233445566778899AABBCCDDEEFF);
    check("seq_busy", u_rx_busy, 128'h0);

    // Bad stop bit on byte 5 drops the partial word
    snap();
    for (int i = 0; i < 5; i++) send_byte(8'h42, 1'b0, -1);
    check("ferr_busy_before", u_rx_busy, 128'h1);
    send_byte(8'h42, 1'b1, -1);
    tick(40);
    check("ferr_pulse", 128'(ferr_cnt - ferr0), 128'h1);
    check("ferr_busy_after", u_rx_busy, 128'h0);
    check("ferr_data_kept", data_out, 128'h00112233445566778899AABBCCDDEEFF);
    snap();
    for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b0, -1);
    tick(4);
    check("a5_done", 128'(done_cnt - done0), 128'h1);
    check("a5_data", data_out, {16{8'hA5}});

    // Reset mid-word
    for (int i = 0; i < 7; i++) send_byte(8'h77, 1'b0, -1);
    check("rst7_busy", u_rx_busy, 128'h1);
    rst_n = 1'b0;
    tick(2);
    check("rst7_data", data_out, 128'h0);
    check("rst7_busy_low", u_rx_busy, 128'h0);
    rst_n = 1'b1;
    tick(5);
    snap();
    for (int i = 0; i < 16; i++) send_byte(8'h5A, 1'b0, -1);
    tick(4);
    check("5a_done", 128'(done_cnt - done0), 128'h1);
    check("5a_data", data_out, {16{8'h5A}});

    // en_rx dropped for one cycle during byte 9 (line low at that point)
    for (int i = 0; i < 8; i++) send_byte(8'h77, 1'b0, -1);
    send_byte(8'h00, 1'b0, 4);
    tick(20);
    check("en_busy_after_drop", u_rx_busy, 128'h0);
    snap();
    for (int i = 0; i < 16; i++) send_byte(8'h3C, 1'b0, -1);
    tick(4);
    check("3c_done", 128'(done_cnt - done0), 128'h1);
    check("3c_ferr", 128'(ferr_cnt - ferr0), 128'h0);
    check("3c_data", data_out, {16{8'h3C}});

    // Partial word left idle
    snap();
    word_snap = {16{8'h3C}};
    for (int i = 0; i < 3; i++) send_byte(8'h99, 1'b0, -1);
    tick(4);
    check("idle_busy_before", u_rx_busy, 128'h1);
    tick(20 * CPB + 20);
`ifdef RX_TIMEOUT_EN
    check("timeout_pulse", 128'(to_cnt - to0), 128'h1);
    check("timeout_busy", u_rx_busy, 128'h0);
`else
    check("timeout_pulse", 128'(to_cnt - to0), 128'h0);
    check("timeout_busy", u_rx_busy, 128'h1);
`endif
    check("timeout_data", data_out, word_snap);
    check("timeout_done", 128'(done_cnt - done0), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
